// File: rtl/fifo_unpacker.sv
// fifo_unpacker: drains FIFO words and serialises them into SYMBOL_WIDTH symbols over valid/ready.
// Define FIFO_UNPACKER_MSB_FIRST_EN to emit the most significant symbol of each word first.
module fifo_unpacker #(
  parameter int WORD_WIDTH   = 32,
  parameter int SYMBOL_WIDTH = 8,
  parameter int READ_CYCLES  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fifo_out_valid,
  input  logic [WORD_WIDTH-1:0]   fifo_out_data,
  input  logic                    fifo_empty,
  output logic                    fifo_out_enable,
  output logic                    sym_valid,
  output logic [SYMBOL_WIDTH-1:0] sym_data,
  output logic                    sym_last,
  input  logic                    sym_ready,
  output logic                    busy
);
  localparam int N  = WORD_WIDTH / SYMBOL_WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  generate
    if ((WORD_WIDTH % SYMBOL_WIDTH) != 0 || N < 2) begin : g_bad_width
      $fatal(1, "fifo_unpacker: WORD_WIDTH must be a multiple (>=2x) of SYMBOL_WIDTH");
    end
    if (READ_CYCLES != 0 && READ_CYCLES != 1) begin : g_bad_latency
      $fatal(1, "fifo_unpacker: READ_CYCLES must be 0 or 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, FETCH, EMIT} state_t;

  state_t                state;
  logic [WORD_WIDTH-1:0] shreg;
  logic [WORD_WIDTH-1:0] shreg_next;
  logic [IW-1:0]         idx;
  logic                  accept;
  logic                  last_accept;

  assign sym_valid   = (state == EMIT);
  assign accept      = sym_valid && sym_ready;
  assign last_accept = accept && (idx == LAST_IDX);
  assign sym_last    = sym_valid && (idx == LAST_IDX);
  assign busy        = (state != IDLE);

`ifdef FIFO_UNPACKER_MSB_FIRST_EN
  assign sym_data   = shreg[WORD_WIDTH-1 -: SYMBOL_WIDTH];
  assign shreg_next = shreg << SYMBOL_WIDTH;
`else
  assign sym_data   = shreg[SYMBOL_WIDTH-1:0];
  assign shreg_next = shreg >> SYMBOL_WIDTH;
`endif

  generate
    if (READ_CYCLES == 0) begin : g_comb_read
      logic unused_empty;
      assign unused_empty = fifo_empty;

      // Pop on the last-symbol accept keeps the stream bubble-free across words.
      assign fifo_out_enable = !rst && fifo_out_valid && (state == IDLE || last_accept);

      always_ff @(posedge clk) begin
        if (rst) begin
          state <= IDLE;
          shreg <= '0;
          idx   <= '0;
        end else if (fifo_out_enable) begin
          state <= EMIT;
          shreg <= fifo_out_data;
          idx   <= '0;
        end else if (accept) begin
          shreg <= shreg_next;
          idx   <= idx + 1'b1;
          if (idx == LAST_IDX) state <= IDLE;
        end
      end
    end else begin : g_reg_read
      logic pop_q;
      assign fifo_out_enable = pop_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          state <= IDLE;
          shreg <= '0;
          idx   <= '0;
          pop_q <= 1'b0;
        end else begin
          pop_q <= 1'b0;
          case (state)
            IDLE: if (!fifo_empty) begin
              pop_q <= 1'b1;
              state <= FETCH;
            end
            FETCH: if (fifo_out_valid) begin
              shreg <= fifo_out_data;
              idx   <= '0;
              state <= EMIT;
            end
            EMIT: if (accept) begin
              shreg <= shreg_next;
              idx   <= idx + 1'b1;
              if (idx == LAST_IDX) state <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_fifo_unpacker.sv
// Bench for fifo_unpacker: one instance per read latency, both fed from queue-based FIFO models
// and checked against a word-to-symbol stream model.
module tb_fifo_unpacker;
  localparam int WW = 32;
  localparam int SW = 8;
  localparam int N  = WW / SW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          fov0 = 1'b0, fe0 = 1'b1, fen0, sv0, sl0, sr0 = 1'b0, busy0;
  logic [WW-1:0] fd0 = '0;
  logic [SW-1:0] sd0;
  logic          fov1 = 1'b0, fe1 = 1'b1, fen1, sv1, sl1, sr1 = 1'b0, busy1;
  logic [WW-1:0] fd1 = '0;
  logic [SW-1:0] sd1;

  fifo_unpacker #(.WORD_WIDTH(WW), .SYMBOL_WIDTH(SW), .READ_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .fifo_out_valid(fov0), .fifo_out_data(fd0), .fifo_empty(fe0),
    .fifo_out_enable(fen0), .sym_valid(sv0), .sym_data(sd0), .sym_last(sl0),
    .sym_ready(sr0), .busy(busy0));

  fifo_unpacker #(.WORD_WIDTH(WW), .SYMBOL_WIDTH(SW), .READ_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .fifo_out_valid(fov1), .fifo_out_data(fd1), .fifo_empty(fe1),
    .fifo_out_enable(fen1), .sym_valid(sv1), .sym_data(sd1), .sym_last(sl1),
    .sym_ready(sr1), .busy(busy1));

  int n_chk = 0;
  int n_fail = 0;

  logic [WW-1:0] src0[$], src1[$];   // words waiting inside each FIFO
  logic [SW:0]   exp0[$], exp1[$];   // {last, data} still owed by each DUT
  int            rem0 = 0, rem1 = 0; // symbols left of the word held
  bit            fetch1 = 0, en1_exp = 0, fv1_nxt = 0;
  logic [WW-1:0] fd1_nxt = '0;
  bit            rst_req = 1, rst_prev = 0, rnd_ready = 0;
  bit            rdy_q[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [SW-1:0] sym_of(input logic [WW-1:0] w, input int k);
`ifdef FIFO_UNPACKER_MSB_FIRST_EN
    return SW'(w >> (SW * (N - 1 - k)));
`else
    return SW'(w >> (SW * k));
`endif
  endfunction

  task automatic cycle();
    bit rdy, pop0, new_en;
    logic [WW-1:0] w;
    @(negedge clk);
    rst = rst_req;
    if (rdy_q.size() != 0) rdy = rdy_q.pop_front();
    else rdy = rnd_ready ? bit'($urandom_range(0, 1)) : 1'b1;
    sr0  = rdy;
    sr1  = rdy;
    fov0 = (src0.size() != 0);
    fd0  = fov0 ? src0[0] : WW'($urandom);
    fe0  = !fov0;
    fe1  = (src1.size() == 0);
    fov1 = fv1_nxt;
    fd1  = fv1_nxt ? fd1_nxt : WW'($urandom);
    #1;
    if (rst) begin
      chk("rst_pop0", fen0, 0);
      if (rst_prev)
        chk("rst_outputs", {fen0, sv0, sd0, sl0, busy0, fen1, sv1, sd1, sl1, busy1}, 0);
    end else begin
      chk("m0_pop", fen0, fov0 && (rem0 == 0 || (rem0 == 1 && rdy)));
      chk("m0_valid", sv0, rem0 > 0);
      chk("m0_busy", busy0, rem0 > 0);
      if (sv0 && exp0.size() != 0) begin
        chk("m0_data", sd0, exp0[0][SW-1:0]);
        chk("m0_last", sl0, exp0[0][SW]);
      end
      chk("m1_pop", fen1, en1_exp);
      chk("m1_valid", sv1, rem1 > 0);
      chk("m1_busy", busy1, rem1 > 0 || fetch1);
      if (sv1 && exp1.size() != 0) begin
        chk("m1_data", sd1, exp1[0][SW-1:0]);
        chk("m1_last", sl1, exp1[0][SW]);
      end
    end
    // FIFO side: pops follow the DUT's request, like a real FIFO would.
    pop0 = fov0 && (rem0 == 0 || (rem0 == 1 && rdy));
    w = fd0;
    if (fen0 && src0.size() != 0) void'(src0.pop_front());
    fv1_nxt = 0;
    if (fen1 && src1.size() != 0) begin
      fv1_nxt = 1;
      fd1_nxt = src1.pop_front();
    end
    if (rst) begin
      rem0 = 0; rem1 = 0; fetch1 = 0; en1_exp = 0;
      exp0.delete(); exp1.delete();
    end else begin
      if (rem0 > 0 && rdy) begin rem0--; if (exp0.size() != 0) void'(exp0.pop_front()); end
      if (pop0) begin
        rem0 = N;
        for (int k = 0; k < N; k++) exp0.push_back({k == N - 1, sym_of(w, k)});
      end
      new_en = (rem1 == 0) && !fetch1 && !fe1;
      if (rem1 > 0 && rdy) begin rem1--; if (exp1.size() != 0) void'(exp1.pop_front()); end
      if (fetch1 && fov1) begin
        fetch1 = 0;
        rem1 = N;
        for (int k = 0; k < N; k++) exp1.push_back({k == N - 1, sym_of(fd1, k)});
      end
      if (new_en) fetch1 = 1;
      en1_exp = new_en;
    end
    rst_prev = rst;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic push_both(input logic [WW-1:0] w);
    src0.push_back(w);
    src1.push_back(w);
  endtask

  initial begin
    bit done;
    // reset held for two cycles while a word sits in the mode-0 FIFO
    src0.push_back(32'h44332211);
    rst_req = 1;
    run(2);
    rst_req = 0;
    run(10);

    // backpressure on a single word
    push_both(32'h44332211);
    rdy_q = '{1, 1, 0, 0, 1, 0, 1, 1};
    run(16);

    // two words back to back in the zero-latency FIFO
    src0.push_back(32'h44332211);
    src0.push_back(32'h88776655);
    run(14);

    // one word through the registered-read FIFO
    src1.push_back(32'hDDCCBBAA);
    run(10);

    // reset after two symbols have been accepted
    push_both(32'h44332211);
    run(3);
    rst_req = 1;
    run(1);
    rst_req = 0;
    push_both(32'h04030201);
    run(14);

    // random traffic with random backpressure and rare resets
    rnd_ready = 1;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0 && src0.size() < 4) push_both(WW'($urandom));
      rst_req = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst_req = 0;
    rnd_ready = 0;

    done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      cycle();
      done = src0.size() == 0 && src1.size() == 0 && rem0 == 0 && rem1 == 0 &&
             !fetch1 && !fv1_nxt;
    end
    chk("drain_done", done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
